// File: rtl/silife_max7219_pkg.sv
// -----------------------------------------------------------------------------
// silife_max7219_pkg
// Definitions shared by the SiLife MAX7219 driver and its receive-side model:
// register address map, SPI word width, the sink FSM state encoding and small
// helpers that split a 16-bit MAX7219 word into its address and data fields.
// -----------------------------------------------------------------------------
package silife_max7219_pkg;

  localparam int WORD_W = 16;

  localparam logic [3:0] ADDR_NOOP      = 4'h0;
  localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
  localparam logic [3:0] ADDR_DIGIT1    = 4'h2;
  localparam logic [3:0] ADDR_DIGIT2    = 4'h3;
  localparam logic [3:0] ADDR_DIGIT3    = 4'h4;
  localparam logic [3:0] ADDR_DIGIT4    = 4'h5;
  localparam logic [3:0] ADDR_DIGIT5    = 4'h6;
  localparam logic [3:0] ADDR_DIGIT6    = 4'h7;
  localparam logic [3:0] ADDR_DIGIT7    = 4'h8;
  localparam logic [3:0] ADDR_DECODE    = 4'h9;
  localparam logic [3:0] ADDR_INTENSITY = 4'hA;
  localparam logic [3:0] ADDR_SCANLIMIT = 4'hB;
  localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
  localparam logic [3:0] ADDR_TEST      = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } state_e;

  // Register address lives in bits [11:8]; bits [15:12] are don't-care.
  function automatic logic [3:0] word_addr(input logic [WORD_W-1:0] w);
    return w[11:8];
  endfunction

  function automatic logic [7:0] word_data(input logic [WORD_W-1:0] w);
    return w[7:0];
  endfunction

  // Digit registers are addressed 1..8; map to array index 0..7.
  function automatic logic [2:0] digit_index(input logic [3:0] addr);
    logic [3:0] idx;
    idx = addr - 4'd1;
    return idx[2:0];
  endfunction

endpackage

// File: rtl/silife_max7219_sink_if.sv
// -----------------------------------------------------------------------------
// silife_max7219_sink_if
// Bundles the SPI pins and the pixel read port of the MAX7219 chain model.
//   i_cs, i_sck, i_mosi : 3-wire SPI from the driver (asynchronous to clk)
//   i_row               : row index for the read port
//   o_row               : lit pixels of the selected row, 8 bits per chip
//   o_enabled           : per-chip shutdown bit (1 = display on)
//   o_load              : one-cycle pulse, valid frame latched
//   o_frame_error       : one-cycle pulse, frame discarded
// master = driver / test side, slave = sink model.
// -----------------------------------------------------------------------------
interface silife_max7219_sink_if #(
  parameter int CHIPS = 4
);
  logic               i_cs;
  logic               i_sck;
  logic               i_mosi;
  logic [2:0]         i_row;
  logic [8*CHIPS-1:0] o_row;
  logic [CHIPS-1:0]   o_enabled;
  logic               o_load;
  logic               o_frame_error;

  modport master (
    output i_cs, i_sck, i_mosi, i_row,
    input  o_row, o_enabled, o_load, o_frame_error
  );

  modport slave (
    input  i_cs, i_sck, i_mosi, i_row,
    output o_row, o_enabled, o_load, o_frame_error
  );
endinterface

// File: rtl/silife_spi_sampler.sv
// -----------------------------------------------------------------------------
// silife_spi_sampler
// Oversamples the SPI pins with clk: 2-flop synchronizers on all three pins,
// a third flop on CS/SCK for edge detection, the chain-wide shift register and
// the modulo-16 bit counter used to judge frame validity.
//   clk, reset   : system clock, async active-low reset
//   i_cs/i_sck/i_mosi : raw SPI pins
//   clear        : hold counter and 'any' cleared (FSM idle)
//   shift_en     : accept SCK rising edges (FSM shifting)
//   frame        : shift register contents, last word in the low bits
//   cs_fall/cs_rise : synchronized CS edge pulses
//   frame_ok     : at least one bit and a whole number of 16-bit words
//   frame_bad    : at least one bit but not a whole number of words
// -----------------------------------------------------------------------------
module silife_spi_sampler
  import silife_max7219_pkg::*;
#(
  parameter int CHIPS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_cs,
  input  logic                    i_sck,
  input  logic                    i_mosi,
  input  logic                    clear,
  input  logic                    shift_en,
  output logic [WORD_W*CHIPS-1:0] frame,
  output logic                    cs_fall,
  output logic                    cs_rise,
  output logic                    frame_ok,
  output logic                    frame_bad
);

  logic [2:0]              cs_sync_r;
  logic [2:0]              sck_sync_r;
  logic [1:0]              mosi_sync_r;
  logic [WORD_W*CHIPS-1:0] shift_r;
  logic [3:0]              cnt_r;
  logic                    any_r;
  logic                    sck_rise_s;
  logic                    shift_now_s;

  // CS synchronizer resets low so a CS already low at reset release produces
  // no falling edge until it has first been seen high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_sync_r   <= 3'b000;
      sck_sync_r  <= 3'b000;
      mosi_sync_r <= 2'b00;
    end else begin
      cs_sync_r   <= {cs_sync_r[1:0], i_cs};
      sck_sync_r  <= {sck_sync_r[1:0], i_sck};
      mosi_sync_r <= {mosi_sync_r[0], i_mosi};
    end
  end

  assign cs_fall    = cs_sync_r[2] & ~cs_sync_r[1];
  assign cs_rise    = ~cs_sync_r[2] & cs_sync_r[1];
  assign sck_rise_s = ~sck_sync_r[2] & sck_sync_r[1];
  // An SCK edge coinciding with the CS rise is not part of the frame.
  assign shift_now_s = shift_en & sck_rise_s & ~cs_rise;

  // Shift register and bit counter; old bits fall off the MSB end.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_r <= '0;
      cnt_r   <= 4'd0;
      any_r   <= 1'b0;
    end else if (clear) begin
      cnt_r   <= 4'd0;
      any_r   <= 1'b0;
    end else if (shift_now_s) begin
      shift_r <= {shift_r[WORD_W*CHIPS-2:0], mosi_sync_r[1]};
      cnt_r   <= cnt_r + 4'd1;
      any_r   <= 1'b1;
    end else begin
      shift_r <= shift_r;
    end
  end

  assign frame     = shift_r;
  assign frame_ok  = any_r & (cnt_r == 4'd0);
  assign frame_bad = any_r & (cnt_r != 4'd0);

endmodule

// File: rtl/silife_max7219_sink.sv
// -----------------------------------------------------------------------------
// silife_max7219_sink
// Receive-side model of a daisy chain of CHIPS MAX7219 8x8 drivers. Decodes
// each completed SPI chain frame into per-chip register writes and exposes the
// resulting pixel image through a combinational row read port.
//   clk   : system clock, at least 4x the SCK rate
//   reset : asynchronous active-low reset
//   bus   : slave side of silife_max7219_sink_if (SPI pins, read port, pulses)
// -----------------------------------------------------------------------------
module silife_max7219_sink
  import silife_max7219_pkg::*;
#(
  parameter int CHIPS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  silife_max7219_sink_if.slave  bus
);

  state_e                  state_r;
  state_e                  state_n_s;
  logic [WORD_W*CHIPS-1:0] frame_s;
  logic [WORD_W-1:0]       words_s [CHIPS];
  logic                    cs_fall_s;
  logic                    cs_rise_s;
  logic                    frame_ok_s;
  logic                    frame_bad_s;
  logic [7:0]              digit_r [CHIPS][8];
  logic [2:0]              scan_limit_r [CHIPS];
  logic [CHIPS-1:0]        shutdown_r;
  logic [CHIPS-1:0]        test_r;
  logic                    load_r;
  logic                    err_r;
  logic [8*CHIPS-1:0]      row_s;

  silife_spi_sampler #(.CHIPS(CHIPS)) u_sampler (
    .clk       (clk),
    .reset     (reset),
    .i_cs      (bus.i_cs),
    .i_sck     (bus.i_sck),
    .i_mosi    (bus.i_mosi),
    .clear     (state_r == ST_IDLE),
    .shift_en  (state_r == ST_SHIFT),
    .frame     (frame_s),
    .cs_fall   (cs_fall_s),
    .cs_rise   (cs_rise_s),
    .frame_ok  (frame_ok_s),
    .frame_bad (frame_bad_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cs_fall_s) begin
          state_n_s = ST_SHIFT;
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cs_rise_s) begin
          state_n_s = ST_LOAD;
        end else begin
          state_n_s = ST_SHIFT;
        end
      end
      ST_LOAD: state_n_s = ST_IDLE;
      default: state_n_s = ST_IDLE;
    endcase
  end

  // Chip k owns word k of the frame; chip 0 holds the last word shifted.
  always_comb begin
    for (int k = 0; k < CHIPS; k++) begin
      words_s[k] = frame_s[WORD_W*k +: WORD_W];
    end
  end

  // Register file update and result pulses on the LOAD cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < CHIPS; k++) begin
        for (int d = 0; d < 8; d++) begin
          digit_r[k][d] <= 8'h00;
        end
        scan_limit_r[k] <= 3'd0;
      end
      shutdown_r <= '0;
      test_r     <= '0;
      load_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      load_r <= 1'b0;
      err_r  <= 1'b0;
      if (state_r == ST_LOAD) begin
        if (frame_ok_s) begin
          load_r <= 1'b1;
          for (int k = 0; k < CHIPS; k++) begin
            case (word_addr(words_s[k]))
              ADDR_DIGIT0, ADDR_DIGIT1, ADDR_DIGIT2, ADDR_DIGIT3,
              ADDR_DIGIT4, ADDR_DIGIT5, ADDR_DIGIT6, ADDR_DIGIT7:
                digit_r[k][digit_index(word_addr(words_s[k]))] <= word_data(words_s[k]);
              ADDR_SCANLIMIT: scan_limit_r[k] <= word_data(words_s[k])
                                                 & 8'h07 ? word_data(words_s[k]) >> 0 : 3'd0;
              ADDR_SHUTDOWN:  shutdown_r[k] <= word_data(words_s[k]) & 8'h01 ? 1'b1 : 1'b0;
              ADDR_TEST:      test_r[k]     <= word_data(words_s[k]) & 8'h01 ? 1'b1 : 1'b0;
              default: ;
            endcase
          end
        end else if (frame_bad_s) begin
          err_r <= 1'b1;
        end else begin
          err_r <= 1'b0;
        end
      end
    end
  end

  // Row read mux; output byte c shows chip CHIPS-1-c.
  always_comb begin
    row_s = '0;
    for (int c = 0; c < CHIPS; c++) begin
      if (test_r[CHIPS-1-c]) begin
        row_s[8*c +: 8] = 8'hFF;
      end else if (!shutdown_r[CHIPS-1-c] || (bus.i_row > scan_limit_r[CHIPS-1-c])) begin
        row_s[8*c +: 8] = 8'h00;
      end else begin
        row_s[8*c +: 8] = digit_r[CHIPS-1-c][bus.i_row];
      end
    end
  end

  assign bus.o_row         = row_s;
  assign bus.o_enabled     = shutdown_r;
  assign bus.o_load        = load_r;
  assign bus.o_frame_error = err_r;

endmodule

// File: tb/tb_silife_max7219_sink.sv
// -----------------------------------------------------------------------------
// tb_silife_max7219_sink
// Directed stimulus for the MAX7219 chain model. Stimulus pushes expected
// load/error events and expected row reads into queues; a monitor on the
// falling clock edge pops and compares whenever the DUT pulses an event or a
// row read is requested.
// -----------------------------------------------------------------------------
module tb_silife_max7219_sink;

  localparam int CHIPS   = 4;
  localparam int EV_LOAD = 1;
  localparam int EV_ERR  = 2;

  typedef struct packed {
    logic [2:0]  r;
    logic [31:0] row;
    logic [3:0]  en;
  } rd_t;

  logic clk = 1'b0;
  logic reset;
  logic rd_req = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   ev_q[$];
  rd_t  rd_q[$];

  always #5 clk = ~clk;

  silife_max7219_sink_if #(.CHIPS(CHIPS)) bus ();

  silife_max7219_sink #(.CHIPS(CHIPS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Monitor: compares DUT events and row reads against queued expectations.
  always @(negedge clk) begin
    int  got;
    int  exp_k;
    rd_t e;
    if (bus.o_load || bus.o_frame_error) begin
      got = (bus.o_load ? EV_LOAD : 0) | (bus.o_frame_error ? EV_ERR : 0);
      tests++;
      if (ev_q.size() == 0) begin
        fails++;
        $display("FAIL event: got kind %0d, required no event", got);
      end else begin
        exp_k = ev_q.pop_front();
        if (got != exp_k) begin
          fails++;
          $display("FAIL event: got kind %0d, required kind %0d", got, exp_k);
        end
      end
    end
    if (rd_req) begin
      tests++;
      if (rd_q.size() == 0) begin
        fails++;
        $display("FAIL read: no expectation queued");
      end else begin
        e = rd_q.pop_front();
        if (bus.o_row !== e.row || bus.o_enabled !== e.en) begin
          fails++;
          $display("FAIL row%0d: got row %h en %b, required row %h en %b",
                   e.r, bus.o_row, bus.o_enabled, e.row, e.en);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Sends the low nbits of data MSB first as one CS-framed transfer.
  task automatic send_bits(input logic [127:0] data, input int nbits);
    bus.i_cs = 1'b0;
    cycles(4);
    for (int i = nbits - 1; i >= 0; i--) begin
      bus.i_mosi = data[i];
      cycles(3);
      bus.i_sck = 1'b1;
      cycles(3);
      bus.i_sck = 1'b0;
    end
    cycles(3);
    bus.i_cs = 1'b1;
    cycles(8);
  endtask

  // Four words, a first (goes to chip 3) ... d last (goes to chip 0).
  task automatic frame4(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] d);
    ev_q.push_back(EV_LOAD);
    send_bits({64'h0, a, b, c, d}, 64);
  endtask

  task automatic rep4(input logic [15:0] w);
    frame4(w, w, w, w);
  endtask

  task automatic check_row(input logic [2:0] r, input logic [31:0] row,
                           input logic [3:0] en);
    rd_t e;
    @(posedge clk);
    bus.i_row = r;
    e.r   = r;
    e.row = row;
    e.en  = en;
    rd_q.push_back(e);
    rd_req = 1'b1;
    @(posedge clk);
    rd_req = 1'b0;
  endtask

  initial begin
    bus.i_cs   = 1'b1;
    bus.i_sck  = 1'b0;
    bus.i_mosi = 1'b0;
    bus.i_row  = 3'd0;
    reset      = 1'b0;
    cycles(5);
    reset = 1'b1;
    cycles(5);

    // Reset state.
    for (int r = 0; r < 8; r++) check_row(3'(r), 32'h0, 4'h0);

    // Init: scan limit 7, display on.
    rep4(16'h0B07);
    rep4(16'h0C01);
    check_row(3'd3, 32'h0, 4'hF);

    // Data round trip on row 3.
    frame4(16'h04AA, 16'h0455, 16'h04F0, 16'h040F);
    check_row(3'd3, 32'h0FF055AA, 4'hF);
    for (int r = 0; r < 8; r++) begin
      if (r != 3) check_row(3'(r), 32'h0, 4'hF);
    end

    // Test mode forces all pixels on.
    rep4(16'h0F01);
    for (int r = 0; r < 8; r++) check_row(3'(r), 32'hFFFFFFFF, 4'hF);
    rep4(16'h0F00);
    check_row(3'd3, 32'h0FF055AA, 4'hF);

    // Framing: 17-bit frame is discarded, 0-bit CS pulse does nothing.
    ev_q.push_back(EV_ERR);
    send_bits(128'h1_0C00, 17);
    bus.i_cs = 1'b0;
    cycles(4);
    bus.i_cs = 1'b1;
    cycles(8);
    check_row(3'd3, 32'h0FF055AA, 4'hF);
    check_row(3'd0, 32'h0, 4'hF);

    // 80-bit frame: the first word (shutdown) falls off the chain.
    ev_q.push_back(EV_LOAD);
    send_bits({48'h0, 16'h0C00, 16'h04AA, 16'h0455, 16'h04F0, 16'h040F}, 80);
    check_row(3'd3, 32'h0FF055AA, 4'hF);

    // Scan limit blanks rows above it.
    rep4(16'h0B03);
    rep4(16'h07FF);
    check_row(3'd6, 32'h0, 4'hF);
    check_row(3'd3, 32'h0FF055AA, 4'hF);
    rep4(16'h0B07);
    check_row(3'd6, 32'hFFFFFFFF, 4'hF);

    // Reset after 7 bits of a frame, CS still low at release.
    bus.i_cs = 1'b0;
    cycles(4);
    for (int i = 0; i < 7; i++) begin
      bus.i_mosi = 1'b1;
      cycles(3);
      bus.i_sck = 1'b1;
      cycles(3);
      bus.i_sck = 1'b0;
    end
    reset = 1'b0;
    cycles(3);
    reset = 1'b1;
    cycles(5);
    for (int r = 0; r < 8; r++) check_row(3'(r), 32'h0, 4'h0);
    bus.i_cs = 1'b1;
    cycles(8);
    rep4(16'h0C01);
    rep4(16'h013C);
    check_row(3'd0, 32'h3C3C3C3C, 4'hF);
    check_row(3'd1, 32'h0, 4'hF);

    cycles(10);
    tests++;
    if (ev_q.size() != 0) begin
      fails++;
      $display("FAIL ev_drain: got %0d pending events, required 0", ev_q.size());
    end
    tests++;
    if (rd_q.size() != 0) begin
      fails++;
      $display("FAIL rd_drain: got %0d pending reads, required 0", rd_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/silife_max7219_sink.md
# silife_max7219_sink

Receive-side model of a daisy-chained MAX7219 LED matrix array. Samples the 3-wire SPI bus (CS/SCK/MOSI) that the SiLife display driver emits and decodes each completed chain frame into per-chip register writes. Presents the resulting lit-pixel image as a row-addressed read port, so driver output can be checked end-to-end on-chip or in simulation. Sits on the display side of the SPI link, oversampling the bus with the system clock.

## Interface
- `CHIPS`, 4, number of cascaded 8x8 devices; display width is 8*CHIPS.
- `clk`  in  1  system clock; must be at least 4x the SCK rate.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `i_cs`  in  1  SPI chip select, active-low, asynchronous to `clk`.
- `i_sck`  in  1  SPI clock; data is sampled on the rising edge; asynchronous.
- `i_mosi`  in  1  SPI data, MSB first; asynchronous.
- `i_row`  in  3  row (digit) index 0..7 for the read port.
- `o_row`  out  8*CHIPS  lit pixels of row `i_row`; combinational from registers.
- `o_enabled`  out  CHIPS  per-chip shutdown register bit 0 (1 = display on).
- `o_load`  out  1  one-cycle pulse when a valid frame is latched.
- `o_frame_error`  out  1  one-cycle pulse when a frame is discarded.

## Operation
- Front end: `i_cs`, `i_sck`, `i_mosi` each pass through 2-flop synchronizers. A third flop on CS and SCK provides edge detection.
- FSM states:
  - IDLE: CS high. Clear the bit counter and the `any` flag. Go to SHIFT on a synchronized CS falling edge.
  - SHIFT: on each synchronized SCK rising edge, shift the synchronized MOSI into bit 0 of a 16*CHIPS-bit shift register. Increment a 4-bit modulo-16 counter and set `any`. On a CS rising edge, go to LOAD.
  - LOAD: one cycle, then IDLE.
- A frame is valid iff `any`=1 and counter==0, i.e. a nonzero multiple of 16 bits.
  - Frames longer than 16*CHIPS bits are valid. Older bits fall off the MSB end, as in a real chain.
- On a valid LOAD, chip k takes word `shift[16k+15:16k]`. Chip 0 receives the last word shifted; the first word goes to chip CHIPS-1.
- Each word splits into addr = bits[11:8] and data = bits[7:0]. Bits[15:12] are ignored.
  - addr 1..8: digit[addr-1] <= data.
  - addr 0xB: scan_limit <= data[2:0].
  - addr 0xC: shutdown <= data[0].
  - addr 0xF: test <= data[0].
  - addr 0 (no-op), 0x9, 0xA, 0xD, 0xE: chip unchanged.
- Invalid LOAD: no register changes; pulse `o_frame_error`.
- Read port: `o_row[8c+7:8c]` shows chip (CHIPS-1-c) as follows.
  - If test=1: 8'hFF.
  - Else if shutdown=0 or `i_row` > scan_limit: 8'h00.
  - Else: digit[`i_row`].
- Reset values: all digits 0, scan_limit 0, shutdown 0, test 0, shift register 0, FSM IDLE, `o_load`=0, `o_frame_error`=0. Consequently `o_row`=0 and `o_enabled`=0.
- Reset asserted mid-frame aborts the frame. After release, the FSM waits in IDLE for a fresh CS falling edge.
  - If CS is already low at reset release, it is ignored until it has been high.
- An SCK edge in the same cycle as the CS rising edge is ignored.
- SCK edges while CS is high are ignored.

## Timing
- Synchronizer latency is 2 cycles. The edge is detected in cycle 3 after the pin transition.
- SCK high and low phases must each last ≥2 `clk` periods. MOSI must be stable across that window.
- Registers update, and `o_load` / `o_frame_error` pulse, at the 4th rising `clk` edge after `i_cs` rises (setup met). The pulse is 1 cycle wide.
- `o_row` follows `i_row` and register contents combinationally, with zero latency.
- Back-to-back frames are accepted with ≥3 `clk` cycles of CS high.

## Structure
- Package `silife_max7219_pkg`: register address constants (NOOP, DIGIT0..7, DECODE, INTENSITY, SCANLIMIT, SHUTDOWN, TEST), the word-width constant 16, and the FSM state enum. This package is shared with the driver.
- Sub-module `silife_spi_sampler`: synchronizers, edge detection, shift register and bit counter. It outputs the frame word vector and pulse signals `cs_fall`, `cs_rise`, `frame_ok`.
- Top module holds the FSM, the per-chip register file and the read mux.

## Test plan
- Reset: assert `reset`=0 mid-frame (after 7 bits) → `o_row`=0 for all 8 rows and `o_enabled`=0. A following clean frame decodes normally.
- Init (CHIPS=4): frame of four 16'h0B07 words, then a frame of four 16'h0C01 words → `o_enabled`=4'b1111 and `o_load` pulses twice.
- Data round trip: after init, send row 3 with words 16'h04AA, 16'h0455, 16'h04F0, 16'h040F in that order → with `i_row`=3, `o_row`=32'h0FF055AA. All other rows read 0.
- Test mode: four 16'h0F01 words → `o_row`=32'hFFFFFFFF for every `i_row`. Four 16'h0F00 words restore 32'h0FF055AA on row 3.
- Framing: a 17-bit frame and a 0-bit CS pulse → `o_frame_error` pulses for the 17-bit frame only. A 0-bit frame produces neither pulse. Registers are unchanged.
- Scan limit: four 16'h0B03 words, then write row 6 data 16'h07FF ×4 → `i_row`=6 reads 0. Row 3 still reads 32'h0FF055AA. Raising the scan limit to 7 makes row 6 read 32'hFFFFFFFF.
